// File: rtl/hub75_bcm_blanker.sv
// hub75_bcm_blanker
//   HUB75 blanking / bit-code-modulation timer. After the shifter has loaded
//   and latched a bit-plane, a go strobe starts one display period. The panel
//   is first held dark for a guard time. It is then lit for 2^plane base
//   units, each (bit_len+1) cycles long. Within each unit only the first
//   on_len cycles are lit, which gives global brightness dimming.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   hub75_blank      panel blank (1 = dark), driven straight from a flop
//   ctrl_plane       bit-plane index; values >= N_PLANES are clamped
//   ctrl_go          start strobe
//   ctrl_abort       synchronous abort of the running plane
//   ctrl_rdy         1 while idle, so a go will be accepted
//   stat_overrun     one-cycle pulse after a go that arrived while busy
//   cfg_bcm_bit_len  base unit length minus one (L)
//   cfg_on_len       lit cycles per unit (ON)
//   cfg_guard        dark cycles before the first unit (G)
//   dbg_state        current FSM state, for observation only
//
// Handshake: a go is accepted on a clock edge where ctrl_go=1, ctrl_rdy=1
// and ctrl_abort=0. A go while ctrl_rdy=0 is dropped and reported on
// stat_overrun, unless abort is also high in that cycle. The plane index and
// all cfg_* values are captured only at acceptance.

module hub75_bcm_blanker #(
  parameter int N_PLANES = 8,
  parameter int BITLEN_W = 8,
  parameter int GUARD_W  = 4,
  localparam int PW = (N_PLANES > 1) ? $clog2(N_PLANES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                hub75_blank,
  input  logic [PW-1:0]       ctrl_plane,
  input  logic                ctrl_go,
  input  logic                ctrl_abort,
  output logic                ctrl_rdy,
  output logic                stat_overrun,
  input  logic [BITLEN_W-1:0] cfg_bcm_bit_len,
  input  logic [BITLEN_W-1:0] cfg_on_len,
  input  logic [GUARD_W-1:0]  cfg_guard,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam logic [PW:0]         PLANE_LIM  = (PW+1)'(N_PLANES);
  localparam logic [PW-1:0]       PLANE_MAX  = PW'(N_PLANES - 1);
  localparam logic [N_PLANES-1:0] UNIT_ONE   = N_PLANES'(1);
  localparam logic [BITLEN_W-1:0] LEN_ONE    = BITLEN_W'(1);
  localparam logic [GUARD_W-1:0]  GUARD_ONE  = GUARD_W'(1);

  logic [1:0]          state, state_n;
  logic [GUARD_W-1:0]  guard_cnt, guard_n;   // guard cycles left, minus one
  logic [N_PLANES-1:0] unit_cnt, unit_n;     // units left after the current one
  logic [BITLEN_W-1:0] u_cnt, u_n;           // cycle index inside the unit
  logic [BITLEN_W-1:0] len_q, len_n;
  logic [BITLEN_W-1:0] on_q, on_n;
  logic                overrun_n;

  logic [PW-1:0]       plane_c;
  logic [N_PLANES-1:0] plane_onehot;
  logic [N_PLANES-1:0] unit_load;

  // Clamp the plane index and turn it into a unit count. The counter holds
  // the number of units remaining after the current one, so load 2^plane-1.
  always_comb begin
    plane_c = ctrl_plane;
    if ({1'b0, ctrl_plane} >= PLANE_LIM) plane_c = PLANE_MAX;
    plane_onehot = '0;
    plane_onehot[plane_c] = 1'b1;
    unit_load = plane_onehot - UNIT_ONE;
  end

  always_comb begin
    state_n   = state;
    guard_n   = guard_cnt;
    unit_n    = unit_cnt;
    u_n       = u_cnt;
    len_n     = len_q;
    on_n      = on_q;
    overrun_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (ctrl_go && !ctrl_abort) begin
          len_n  = cfg_bcm_bit_len;
          on_n   = cfg_on_len;
          unit_n = unit_load;
          u_n    = '0;
          if (cfg_guard != '0) begin
            state_n = S_GUARD;
            guard_n = cfg_guard - GUARD_ONE;
          end else begin
            state_n = S_SHOW;
          end
        end
      end
      S_GUARD: begin
        if (guard_cnt == '0) begin
          state_n = S_SHOW;
          u_n     = '0;
        end else begin
          guard_n = guard_cnt - GUARD_ONE;
        end
      end
      S_SHOW: begin
        if (u_cnt == len_q) begin
          u_n = '0;
          if (unit_cnt == '0) state_n = S_IDLE;
          else                unit_n  = unit_cnt - UNIT_ONE;
        end else begin
          u_n = u_cnt + LEN_ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Abort overrides everything that happens in a busy cycle, including a
    // natural end and an overrun report.
    if (state != S_IDLE) begin
      if (ctrl_abort) begin
        state_n = S_IDLE;
        guard_n = '0;
        unit_n  = '0;
        u_n     = '0;
      end else if (ctrl_go) begin
        overrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      guard_cnt    <= '0;
      unit_cnt     <= '0;
      u_cnt        <= '0;
      len_q        <= '0;
      on_q         <= '0;
      hub75_blank  <= 1'b1;
      ctrl_rdy     <= 1'b1;
      stat_overrun <= 1'b0;
    end else begin
      state        <= state_n;
      guard_cnt    <= guard_n;
      unit_cnt     <= unit_n;
      u_cnt        <= u_n;
      len_q        <= len_n;
      on_q         <= on_n;
      // Outputs are loaded from next-state values so they line up exactly
      // with the state they describe.
      hub75_blank  <= !((state_n == S_SHOW) && (u_n < on_n));
      ctrl_rdy     <= (state_n == S_IDLE);
      stat_overrun <= overrun_n;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_hub75_bcm_blanker.sv
module tb_hub75_bcm_blanker;

  logic       clk = 1'b0;
  logic       rst;
  logic       hub75_blank;
  logic [2:0] ctrl_plane;
  logic       ctrl_go;
  logic       ctrl_abort;
  logic       ctrl_rdy;
  logic       stat_overrun;
  logic [7:0] cfg_bcm_bit_len;
  logic [7:0] cfg_on_len;
  logic [3:0] cfg_guard;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  hub75_bcm_blanker dut (
    .clk(clk), .rst(rst), .hub75_blank(hub75_blank),
    .ctrl_plane(ctrl_plane), .ctrl_go(ctrl_go), .ctrl_abort(ctrl_abort),
    .ctrl_rdy(ctrl_rdy), .stat_overrun(stat_overrun),
    .cfg_bcm_bit_len(cfg_bcm_bit_len), .cfg_on_len(cfg_on_len),
    .cfg_guard(cfg_guard), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one display period is a window of absolute cycle numbers
  // [b_start, b_end]; the first mg cycles are guard, the rest are units.
  int   t;
  int   b_start, b_end, mg, ml, mon;
  logic ovr_m;
  logic [2:0] exp_q[$];   // {blank, rdy, overrun} for each upcoming cycle
  logic a_blank, a_rdy, a_ovr;

  function automatic logic m_busy();
    return (t >= b_start) && (t <= b_end);
  endfunction

  function automatic logic [2:0] model_out();
    logic lit;
    int   k;
    lit = 1'b0;
    if (m_busy() && (t >= b_start + mg)) begin
      k   = (t - b_start - mg) % (ml + 1);
      lit = (k < mon);
    end
    return {!lit, !m_busy(), ovr_m};
  endfunction

  task automatic lit_chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, t, act, exp);
    end
  endtask

  task automatic check_now();
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty cycle=%0d got=0 want=1", t);
      return;
    end
    e = exp_q.pop_front();
    a_blank = hub75_blank;
    a_rdy   = ctrl_rdy;
    a_ovr   = stat_overrun;
    lit_chk("blank", a_blank, e[2]);
    lit_chk("rdy", a_rdy, e[1]);
    lit_chk("overrun", a_ovr, e[0]);
    lit_chk("state_idle", (dbg_state == 2'd0), e[1]);
  endtask

  task automatic advance(input logic go, input logic ab, input int pl,
                         input int l, input int on, input int g);
    logic busy;
    busy  = m_busy();
    ovr_m = go && !ab && busy;
    if (ab && busy) b_end = t;
    else if (!busy && go && !ab) begin
      b_start = t + 1;
      b_end   = t + g + (1 << pl) * (l + 1);
      mg = g; ml = l; mon = on;
    end
    t++;
    exp_q.push_back(model_out());
  endtask

  // One clock: check the current cycle, drive inputs, predict the next cycle.
  task automatic step(input logic go, input logic ab, input int pl,
                      input int l, input int on, input int g);
    check_now();
    ctrl_go         = go;
    ctrl_abort      = ab;
    ctrl_plane      = pl[2:0];
    cfg_bcm_bit_len = l[7:0];
    cfg_on_len      = on[7:0];
    cfg_guard       = g[3:0];
    advance(go, ab, pl, l, on, g);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, $urandom_range(0, 7), $urandom_range(0, 255),
         $urandom_range(0, 255), $urandom_range(0, 15));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy() && n < 2000) begin
      idle();
      n++;
    end
    if (m_busy()) lit_chk("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic test1();
    step(1'b1, 1'b0, 0, 3, 4, 0);
    for (int c = 1; c <= 4; c++) begin
      idle();
      lit_chk("t1_lit", a_blank, 1'b0);
      lit_chk("t1_busy", a_rdy, 1'b0);
    end
    idle();
    lit_chk("t1_rdy", a_rdy, 1'b1);
    lit_chk("t1_dark", a_blank, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    ctrl_go = 0; ctrl_abort = 0; ctrl_plane = 0;
    cfg_bcm_bit_len = 0; cfg_on_len = 0; cfg_guard = 0;
    #12;
    lit_chk("reset_blank", hub75_blank, 1'b1);
    lit_chk("reset_rdy", ctrl_rdy, 1'b1);
    lit_chk("reset_ovr", stat_overrun, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    t = 0; b_start = 0; b_end = -1; mg = 0; ml = 0; mon = 0; ovr_m = 1'b0;
    exp_q.push_back(model_out());

    // 1: single unit, fully lit
    test1();

    // 2: guard then four dimmed units
    step(1'b1, 1'b0, 2, 3, 2, 2);
    for (int c = 1; c <= 18; c++) begin
      idle();
      lit_chk("t2_blank", a_blank, (c <= 2) ? 1'b1 : (((c - 3) % 4) >= 2));
    end
    idle();
    lit_chk("t2_rdy", a_rdy, 1'b1);

    // 3: ON=0 keeps the panel dark
    step(1'b1, 1'b0, 1, 1, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      idle();
      lit_chk("t3_dark", a_blank, 1'b1);
      lit_chk("t3_busy", a_rdy, 1'b0);
    end
    idle();
    lit_chk("t3_rdy", a_rdy, 1'b1);

    // 4: overrun while busy
    step(1'b1, 1'b0, 3, 7, 8, 0);
    for (int c = 1; c <= 4; c++) idle();
    step(1'b1, 1'b0, 0, 0, 1, 0);
    for (int c = 6; c <= 65; c++) begin
      idle();
      lit_chk("t4_ovr", a_ovr, (c == 6));
      if (c == 64) lit_chk("t4_busy_end", a_rdy, 1'b0);
      if (c == 65) lit_chk("t4_rdy", a_rdy, 1'b1);
    end

    // 5: abort, then go+abort, then go
    step(1'b1, 1'b0, 3, 7, 8, 0);
    for (int c = 1; c <= 9; c++) idle();
    step(1'b0, 1'b1, 0, 0, 0, 0);
    lit_chk("t5_lit_before_abort", a_blank, 1'b0);
    step(1'b1, 1'b1, 0, 3, 4, 0);
    lit_chk("t5_abort_rdy", a_rdy, 1'b1);
    lit_chk("t5_abort_blank", a_blank, 1'b1);
    step(1'b1, 1'b0, 0, 3, 4, 0);
    lit_chk("t5_still_idle", a_rdy, 1'b1);
    lit_chk("t5_no_ovr", a_ovr, 1'b0);
    idle();
    lit_chk("t5_started", a_rdy, 1'b0);
    lit_chk("t5_started_lit", a_blank, 1'b0);
    wait_idle();

    // 6: asynchronous reset mid-SHOW, then normal operation
    step(1'b1, 1'b0, 2, 3, 4, 0);
    idle();
    idle();
    ctrl_go = 0; ctrl_abort = 0;
    #3 rst = 1'b1;
    #1;
    lit_chk("t6_async_blank", hub75_blank, 1'b1);
    lit_chk("t6_async_rdy", ctrl_rdy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    t++; b_start = 0; b_end = -1; ovr_m = 1'b0;
    exp_q.push_back(model_out());
    test1();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0),
           $urandom_range(0, 5), $urandom_range(0, 5),
           $urandom_range(0, 7), $urandom_range(0, 3));
    end
    wait_idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
